// File: rtl/pfloat_to_pfixed_param_pkg.sv
// Shared types and derived constants for the float-to-fixed converter.
// Shift limits are expressed in the exponent-derived shift domain used by CLASSIFY.
package pfloat_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        CLASSIFY,
        ALIGN,
        ROUND,
        DONE
    } state_t;

    localparam logic RND_TRUNC = 1'b0;
    localparam logic RND_RNE   = 1'b1;

    function automatic int exp_bias(input int exp_w);
        return (1 << (exp_w - 1)) - 1;
    endfunction

    function automatic int acc_width(input int fix_w, input int man_w);
        return fix_w + man_w + 2;
    endfunction

    // Largest left shift that cannot reach the sign bit for any significand.
    function automatic int shift_max(input int fix_w, input int man_w);
        return fix_w - 2 - man_w;
    endfunction

    // Below this, the hidden one lands under the round bit and the result is always zero.
    function automatic int shift_min(input int man_w);
        return -(man_w + 2);
    endfunction

endpackage

// File: rtl/pfloat_to_pfixed_param_if.sv
// Request/acknowledge bus between a datapath controller and the float-to-fixed converter.
interface pfloat_to_pfixed_param_if #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23,
    parameter int FIX_W = 32
);

    logic                   begin_ff;
    logic                   rnd_mode;
    logic [EXP_W+MAN_W:0]   f;
    logic                   ack_ff;
    logic                   busy;
    logic [FIX_W-1:0]       result;
    logic                   ovf;
    logic                   unf;
    logic                   inv;

    modport master (
        output begin_ff, rnd_mode, f,
        input  ack_ff, busy, result, ovf, unf, inv
    );

    modport slave (
        input  begin_ff, rnd_mode, f,
        output ack_ff, busy, result, ovf, unf, inv
    );

endinterface

// File: rtl/pfloat_to_pfixed_param_fix_align_shifter.sv
// Multi-cycle alignment shifter: moves the significand at most SHSTEP places per step,
// keeping guard/round bits below the integer LSB and a sticky OR of everything lost.
module fix_align_shifter
    import pfloat_pkg::*;
#(
    parameter int ACC_W  = 57,
    parameter int AMT_W  = 6,
    parameter int SHSTEP = 4
) (
    input  logic             clk,
    input  logic             rst_ff,
    input  logic             load,
    input  logic             step_en,
    input  logic [ACC_W-1:0] sig_in,
    input  logic             left,
    input  logic [AMT_W-1:0] amount,
    output logic [ACC_W-1:0] acc,
    output logic             guard,
    output logic             round_bit,
    output logic             sticky,
    output logic             done
);

    logic [ACC_W+1:0] ext_q;
    logic [AMT_W-1:0] rem_q;
    logic             left_q;
    logic             sticky_q;
    logic [AMT_W-1:0] step;
    logic [ACC_W+1:0] drop_mask;

    always_comb begin
        step      = (rem_q > AMT_W'(SHSTEP)) ? AMT_W'(SHSTEP) : rem_q;
        drop_mask = ~({(ACC_W+2){1'b1}} << step);
        done      = (rem_q <= AMT_W'(SHSTEP));
    end

    // done is combinational so the FSM leaves ALIGN on the same edge as the final step.
    always_ff @(posedge clk) begin
        if (rst_ff) begin
            ext_q    <= '0;
            rem_q    <= '0;
            left_q   <= 1'b0;
            sticky_q <= 1'b0;
        end else if (load) begin
            ext_q    <= {sig_in, 2'b00};
            rem_q    <= amount;
            left_q   <= left;
            sticky_q <= 1'b0;
        end else if (step_en) begin
            if (left_q) begin
                ext_q <= ext_q << step;
            end else begin
                ext_q    <= ext_q >> step;
                sticky_q <= sticky_q | (|(ext_q & drop_mask));
            end
            rem_q <= rem_q - step;
        end
    end

    assign acc       = ext_q[ACC_W+1:2];
    assign guard     = ext_q[1];
    assign round_bit = ext_q[0];
    assign sticky    = sticky_q;

endmodule

// File: rtl/pfloat_to_pfixed_param.sv
// Handshaked float-to-fixed converter with truncate/RNE rounding, saturation and
// exception flags; alignment is delegated to fix_align_shifter.
module pfloat_to_pfixed_param
    import pfloat_pkg::*;
#(
    parameter int EXP_W  = 8,
    parameter int MAN_W  = 23,
    parameter int FIX_W  = 32,
    parameter int FRAC_W = 16,
    parameter int SHSTEP = 4
) (
    input logic                    clk,
    input logic                    rst_ff,
    pfloat_to_pfixed_param_if.slave bus
);

    localparam int ACC_W  = acc_width(FIX_W, MAN_W);
    localparam int AMT_W  = $clog2(ACC_W + 1);
    localparam int BIAS   = exp_bias(EXP_W);
    localparam int SH_MAX = shift_max(FIX_W, MAN_W);
    localparam int SH_MIN = shift_min(MAN_W);

    localparam logic [FIX_W-1:0] SAT_POS = {1'b0, {(FIX_W-1){1'b1}}};
    localparam logic [FIX_W-1:0] SAT_NEG = {1'b1, {(FIX_W-1){1'b0}}};
    localparam logic [ACC_W:0]   MAX_POS = {{(ACC_W+2-FIX_W){1'b0}}, {(FIX_W-1){1'b1}}};
    localparam logic [ACC_W:0]   MIN_MAG = MAX_POS + 1'b1;

    state_t           state;
    logic             sign_q;
    logic [EXP_W-1:0] exp_q;
    logic [MAN_W-1:0] man_q;
    logic             rnd_q;

    int               sh;
    logic             sh_left;
    logic [AMT_W-1:0] sh_amt;
    logic             min_exact;

    logic [ACC_W-1:0] acc;
    logic             guard;
    logic             round_bit;
    logic             sticky;
    logic             align_done;

    logic             inc;
    logic [ACC_W:0]   mag;
    logic             ovf_r;
    logic [FIX_W-1:0] fix_mag;
    logic [FIX_W-1:0] fix_val;

    // Exactly -2^(FIX_W-1) lies one shift beyond SH_MAX but is representable, so it aligns normally.
    always_comb begin
        sh        = int'(exp_q) - BIAS + FRAC_W - MAN_W;
        sh_left   = (sh > 0);
        sh_amt    = AMT_W'(sh_left ? sh : -sh);
        min_exact = sign_q && (sh == SH_MAX + 1) && (man_q == '0);
    end

    fix_align_shifter #(
        .ACC_W  (ACC_W),
        .AMT_W  (AMT_W),
        .SHSTEP (SHSTEP)
    ) u_align (
        .clk       (clk),
        .rst_ff    (rst_ff),
        .load      (state == CLASSIFY),
        .step_en   (state == ALIGN),
        .sig_in    (ACC_W'({1'b1, man_q})),
        .left      (sh_left),
        .amount    (sh_amt),
        .acc       (acc),
        .guard     (guard),
        .round_bit (round_bit),
        .sticky    (sticky),
        .done      (align_done)
    );

    always_comb begin
        inc     = (rnd_q == RND_RNE) && guard && (round_bit || sticky || acc[0]);
        mag     = {1'b0, acc} + {{ACC_W{1'b0}}, inc};
        ovf_r   = sign_q ? (mag > MIN_MAG) : (mag > MAX_POS);
        fix_mag = mag[FIX_W-1:0];
        fix_val = sign_q ? -fix_mag : fix_mag;
    end

    always_ff @(posedge clk) begin
        if (rst_ff) begin
            state      <= IDLE;
            sign_q     <= 1'b0;
            exp_q      <= '0;
            man_q      <= '0;
            rnd_q      <= RND_TRUNC;
            bus.ack_ff <= 1'b0;
            bus.busy   <= 1'b0;
            bus.result <= '0;
            bus.ovf    <= 1'b0;
            bus.unf    <= 1'b0;
            bus.inv    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.begin_ff) begin
                        {sign_q, exp_q, man_q} <= bus.f;
                        rnd_q    <= bus.rnd_mode;
                        bus.busy <= 1'b1;
                        bus.ovf  <= 1'b0;
                        bus.unf  <= 1'b0;
                        bus.inv  <= 1'b0;
                        state    <= LOAD;
                    end
                end
                LOAD: state <= CLASSIFY;
                CLASSIFY: begin
                    if (exp_q == '0) begin
                        bus.result <= '0;
                        bus.unf    <= (man_q != '0);
                        bus.ack_ff <= 1'b1;
                        bus.busy   <= 1'b0;
                        state      <= DONE;
                    end else if (&exp_q) begin
                        if (man_q != '0) begin
                            bus.inv    <= 1'b1;
                            bus.result <= '0;
                        end else begin
                            bus.ovf    <= 1'b1;
                            bus.result <= sign_q ? SAT_NEG : SAT_POS;
                        end
                        bus.ack_ff <= 1'b1;
                        bus.busy   <= 1'b0;
                        state      <= DONE;
                    end else if (sh > SH_MAX && !min_exact) begin
                        bus.ovf    <= 1'b1;
                        bus.result <= sign_q ? SAT_NEG : SAT_POS;
                        bus.ack_ff <= 1'b1;
                        bus.busy   <= 1'b0;
                        state      <= DONE;
                    end else if (sh < SH_MIN) begin
                        bus.result <= '0;
                        bus.unf    <= 1'b1;
                        bus.ack_ff <= 1'b1;
                        bus.busy   <= 1'b0;
                        state      <= DONE;
                    end else begin
                        state <= ALIGN;
                    end
                end
                ALIGN: begin
                    if (align_done) begin
                        state <= ROUND;
                    end
                end
                ROUND: begin
                    bus.result <= ovf_r ? (sign_q ? SAT_NEG : SAT_POS) : fix_val;
                    bus.ovf    <= ovf_r;
                    bus.unf    <= !ovf_r && (mag == '0);
                    bus.ack_ff <= 1'b1;
                    bus.busy   <= 1'b0;
                    state      <= DONE;
                end
                DONE: begin
                    if (!bus.begin_ff) begin
                        bus.ack_ff <= 1'b0;
                        state      <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
